// File: rtl/subservient_mem_arbiter.sv
// -----------------------------------------------------------------------------
// subservient_mem_arbiter
//
// Shares one single-port 32-bit SRAM between the management SoC Wishbone
// slave port and the subservient core's memory bus. It also holds the core in
// reset until the management side has loaded firmware and set the RUN bit.
//
// Handshake: a master raises its request (wbs_cyc_i & wbs_stb_i inside the
// BASE_ADDR window, or core_cyc_i while the core is out of reset) and holds
// address/data/we/sel stable until it sees its ack for one cycle. The ack is
// only ever given while that same request is still present; a request that
// vanishes mid-access completes at the SRAM but goes unacknowledged.
//
// Ports:
//   wb_clk_i, wb_rst_ni        clock, asynchronous active-low reset
//   wbs_*                      management Wishbone slave (cyc/stb/we/sel/adr/dat, ack/dat_o)
//   core_*                     core bus (cyc/we/sel/adr/dat, ack/dat_o); no stb
//   core_rst_no                core reset, active low (RUN delayed one cycle)
//   sram_en_o/we_o/addr_o/wdata_o/rdata_i   SRAM macro, rdata valid the cycle after en
//   dbg_state                  current FSM state (0 IDLE, 1 REG, 2 ACC, 3 RESP)
// -----------------------------------------------------------------------------
module subservient_mem_arbiter #(
   parameter int          AW        = 10,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_ni,
   input  logic          wbs_cyc_i,
   input  logic          wbs_stb_i,
   input  logic          wbs_we_i,
   input  logic [3:0]    wbs_sel_i,
   input  logic [31:0]   wbs_adr_i,
   input  logic [31:0]   wbs_dat_i,
   output logic          wbs_ack_o,
   output logic [31:0]   wbs_dat_o,
   input  logic          core_cyc_i,
   input  logic          core_we_i,
   input  logic [3:0]    core_sel_i,
   input  logic [31:0]   core_adr_i,
   input  logic [31:0]   core_dat_i,
   output logic          core_ack_o,
   output logic [31:0]   core_dat_o,
   output logic          core_rst_no,
   output logic          sram_en_o,
   output logic [3:0]    sram_we_o,
   output logic [AW-1:0] sram_addr_o,
   output logic [31:0]   sram_wdata_o,
   input  logic [31:0]   sram_rdata_i,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REG  = 2'd1,
      S_ACC  = 2'd2,
      S_RESP = 2'd3
   } state_t;

   localparam logic G_CORE = 1'b0;
   localparam logic G_MGMT = 1'b1;

   state_t state;
   logic   run;
   logic   last_grant;
   logic   grant;

   logic   mgmt_req;
   logic   mgmt_ctrl;
   logic   mgmt_sram;
   logic   core_req;
   logic   pick_mgmt;
   logic   unused_bits;

   assign mgmt_req  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_ADDR[31:24]);
   assign mgmt_ctrl = mgmt_req &  wbs_adr_i[AW+2];
   assign mgmt_sram = mgmt_req & ~wbs_adr_i[AW+2];
   // A core still held in reset cannot reach the SRAM.
   assign core_req  = core_cyc_i & core_rst_no;

   // Round robin on contention: the master that did not win last time goes.
   assign pick_mgmt = mgmt_sram & (~core_req | (last_grant == G_CORE));

   assign dbg_state = state;

   // Address bits outside the SRAM word index are deliberately ignored.
   assign unused_bits = ^{wbs_adr_i[23:AW+3], wbs_adr_i[1:0],
                          core_adr_i[31:AW+2], core_adr_i[1:0]};

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state        <= S_IDLE;
         run          <= 1'b0;
         last_grant   <= G_CORE;
         grant        <= G_CORE;
         core_rst_no  <= 1'b0;
         sram_en_o    <= 1'b0;
         sram_we_o    <= 4'b0;
         sram_addr_o  <= '0;
         sram_wdata_o <= 32'b0;
      end else begin
         core_rst_no <= run;
         case (state)
            S_IDLE: begin
               if (mgmt_ctrl) begin
                  state <= S_REG;
               end else if (mgmt_sram || core_req) begin
                  grant      <= pick_mgmt;
                  last_grant <= pick_mgmt;
                  sram_en_o  <= 1'b1;
                  if (pick_mgmt) begin
                     sram_addr_o  <= wbs_adr_i[AW+1:2];
                     sram_we_o    <= wbs_we_i ? wbs_sel_i : 4'b0;
                     sram_wdata_o <= wbs_dat_i;
                  end else begin
                     sram_addr_o  <= core_adr_i[AW+1:2];
                     sram_we_o    <= core_we_i ? core_sel_i : 4'b0;
                     sram_wdata_o <= core_dat_i;
                  end
                  state <= S_ACC;
               end
            end
            S_ACC: begin
               sram_en_o <= 1'b0;
               sram_we_o <= 4'b0;
               state     <= S_RESP;
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            S_REG: begin
               if (wbs_cyc_i && wbs_stb_i && wbs_we_i && wbs_sel_i[0]) begin
                  run <= wbs_dat_i[0];
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Acks are decoded from registered state and gated by the live request,
   // so a master that abandoned its cycle never sees a stray ack. Read data
   // is steered only while acking and is zero otherwise.
   always_comb begin
      wbs_ack_o  = 1'b0;
      wbs_dat_o  = 32'b0;
      core_ack_o = 1'b0;
      core_dat_o = 32'b0;
      if (state == S_REG && wbs_cyc_i && wbs_stb_i) begin
         wbs_ack_o = 1'b1;
         wbs_dat_o = {30'b0, core_rst_no, run};
      end else if (state == S_RESP) begin
         if (grant == G_MGMT && wbs_cyc_i && wbs_stb_i) begin
            wbs_ack_o = 1'b1;
            wbs_dat_o = sram_rdata_i;
         end
         if (grant == G_CORE && core_cyc_i && core_rst_no) begin
            core_ack_o = 1'b1;
            core_dat_o = sram_rdata_i;
         end
      end
   end

endmodule

// File: tb/tb_subservient_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_subservient_mem_arbiter
//
// Directed bench for subservient_mem_arbiter with a behavioural SRAM macro.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_subservient_mem_arbiter;

   localparam int AW = 10;
   localparam logic [31:0] CTRL_ADR = 32'h3000_0000 | (32'h1 << (AW + 2));

   logic          clk;
   logic          rst_n;
   logic          wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]    wbs_sel_i;
   logic [31:0]   wbs_adr_i, wbs_dat_i;
   logic          wbs_ack_o;
   logic [31:0]   wbs_dat_o;
   logic          core_cyc_i, core_we_i;
   logic [3:0]    core_sel_i;
   logic [31:0]   core_adr_i, core_dat_i;
   logic          core_ack_o;
   logic [31:0]   core_dat_o;
   logic          core_rst_no;
   logic          sram_en_o;
   logic [3:0]    sram_we_o;
   logic [AW-1:0] sram_addr_o;
   logic [31:0]   sram_wdata_o;
   logic [31:0]   sram_rdata_i;
   logic [1:0]    dbg_state;

   int n_cmp;
   int n_err;

   subservient_mem_arbiter #(.AW(AW), .BASE_ADDR(32'h3000_0000)) dut (
      .wb_clk_i     (clk),
      .wb_rst_ni    (rst_n),
      .wbs_cyc_i    (wbs_cyc_i),
      .wbs_stb_i    (wbs_stb_i),
      .wbs_we_i     (wbs_we_i),
      .wbs_sel_i    (wbs_sel_i),
      .wbs_adr_i    (wbs_adr_i),
      .wbs_dat_i    (wbs_dat_i),
      .wbs_ack_o    (wbs_ack_o),
      .wbs_dat_o    (wbs_dat_o),
      .core_cyc_i   (core_cyc_i),
      .core_we_i    (core_we_i),
      .core_sel_i   (core_sel_i),
      .core_adr_i   (core_adr_i),
      .core_dat_i   (core_dat_i),
      .core_ack_o   (core_ack_o),
      .core_dat_o   (core_dat_o),
      .core_rst_no  (core_rst_no),
      .sram_en_o    (sram_en_o),
      .sram_we_o    (sram_we_o),
      .sram_addr_o  (sram_addr_o),
      .sram_wdata_o (sram_wdata_o),
      .sram_rdata_i (sram_rdata_i),
      .dbg_state    (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural SRAM ----------------
   logic [31:0] mem [0:(1<<AW)-1];
   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
      sram_rdata_i = 32'h0;
   end
   always @(posedge clk) begin
      if (sram_en_o) begin
         for (int b = 0; b < 4; b++) begin
            if (sram_we_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
         end
         sram_rdata_i <= mem[sram_addr_o];
      end
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // One management transfer. lat counts negedges from the request cycle to
   // the ack (0 when no ack within the budget); the acc_* outputs capture the
   // SRAM port while sram_en_o was high.
   task automatic mgmt_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                            input logic [31:0] dat, output logic [31:0] rdat, output int lat,
                            output logic [31:0] acc_addr, output logic [31:0] acc_we,
                            output logic [31:0] acc_wdata);
      rdat = 32'h0; lat = 0; acc_addr = 32'hFFFF_FFFF; acc_we = 32'hFFFF_FFFF; acc_wdata = 32'h0;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (sram_en_o) begin
            acc_addr = 32'(sram_addr_o); acc_we = 32'(sram_we_o); acc_wdata = sram_wdata_o;
         end
         if (wbs_ack_o) begin
            lat = i; rdat = wbs_dat_o;
            break;
         end
      end
      tick();
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] rd, a_addr, a_we, a_wd;
   int          lat;

   initial begin
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0;
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
      core_cyc_i = 1'b1; core_we_i = 0; core_sel_i = 4'hF; core_adr_i = 32'h10; core_dat_i = 0;

      // Reset values, then 10 idle cycles with the core requesting.
      #12;
      check_eq("rst_core_rst_no", 32'(core_rst_no), 32'h0);
      check_eq("rst_sram_en",     32'(sram_en_o),   32'h0);
      check_eq("rst_state",       32'(dbg_state),   32'h0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("idle_core_rst_no", 32'(core_rst_no), 32'h0);
         check_eq("idle_no_access",   32'({sram_en_o, wbs_ack_o, core_ack_o}), 32'h0);
      end
      tick();
      core_cyc_i = 1'b0;

      // Full-word write and read-back.
      mgmt_xfer(1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, rd, lat, a_addr, a_we, a_wd);
      check_eq("wr_latency", 32'(lat), 32'd3);
      check_eq("wr_addr",    a_addr,   32'd4);
      check_eq("wr_we",      a_we,     32'hF);
      check_eq("wr_wdata",   a_wd,     32'hDEAD_BEEF);
      mgmt_xfer(1'b0, 4'hF, 32'h3000_0010, 32'h0, rd, lat, a_addr, a_we, a_wd);
      check_eq("rd_latency", 32'(lat), 32'd3);
      check_eq("rd_we",      a_we,     32'h0);
      check_eq("rd_data",    rd,       32'hDEAD_BEEF);

      // Byte-lane write.
      mgmt_xfer(1'b1, 4'hF, 32'h3000_0020, 32'h1122_3344, rd, lat, a_addr, a_we, a_wd);
      mgmt_xfer(1'b1, 4'h2, 32'h3000_0020, 32'h0000_AB00, rd, lat, a_addr, a_we, a_wd);
      check_eq("byte_we", a_we, 32'h2);
      mgmt_xfer(1'b0, 4'hF, 32'h3000_0020, 32'h0, rd, lat, a_addr, a_we, a_wd);
      check_eq("byte_rd", rd, 32'h1122_AB44);

      // Out-of-window request is never acked and never reaches the SRAM.
      mgmt_xfer(1'b1, 4'hF, 32'h4000_0010, 32'h5555_5555, rd, lat, a_addr, a_we, a_wd);
      check_eq("oow_no_ack",    32'(lat), 32'd0);
      check_eq("oow_no_access", a_addr,   32'hFFFF_FFFF);

      // CTRL write releases the core one cycle after RUN is set.
      mgmt_xfer(1'b1, 4'h1, CTRL_ADR, 32'h1, rd, lat, a_addr, a_we, a_wd);
      check_eq("ctrl_wr_latency", 32'(lat), 32'd2);
      @(negedge clk);
      check_eq("run_delay_0", 32'(core_rst_no), 32'h0);
      @(negedge clk);
      check_eq("run_delay_1", 32'(core_rst_no), 32'h1);
      tick();
      mgmt_xfer(1'b0, 4'hF, CTRL_ADR, 32'h0, rd, lat, a_addr, a_we, a_wd);
      check_eq("ctrl_rd_latency", 32'(lat), 32'd2);
      check_eq("ctrl_rd_data",    rd,       32'h3);

      // Contention after reset: mgmt first, then alternation while both held.
      do_reset();
      mgmt_xfer(1'b1, 4'h1, CTRL_ADR, 32'h1, rd, lat, a_addr, a_we, a_wd);
      tick();
      tick();
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0010;
      core_cyc_i = 1; core_we_i = 0; core_sel_i = 4'hF; core_adr_i = 32'h1234_5020; // aliases word 8
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         case (i)
            2: check_eq("arb1_addr_mgmt", 32'(sram_addr_o), 32'd4);
            3: begin
               check_eq("arb1_mgmt_ack", 32'({wbs_ack_o, core_ack_o}), 32'h2);
               check_eq("arb1_mgmt_dat", wbs_dat_o, 32'hDEAD_BEEF);
            end
            5: check_eq("arb2_addr_core", 32'(sram_addr_o), 32'd8);
            6: begin
               check_eq("arb2_core_ack", 32'({wbs_ack_o, core_ack_o}), 32'h1);
               check_eq("arb2_core_dat", core_dat_o, 32'h1122_AB44);
               check_eq("arb2_wbs_dat0", wbs_dat_o,  32'h0);
            end
            8: check_eq("arb3_addr_mgmt", 32'(sram_addr_o), 32'd4);
            9: check_eq("arb3_mgmt_ack", 32'({wbs_ack_o, core_ack_o}), 32'h2);
            default: ;
         endcase
      end
      tick();
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_adr_i = 0;
      core_cyc_i = 0; core_adr_i = 0;
      tick();

      // Reset during the ACC cycle of a write.
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
      wbs_adr_i = 32'h3000_0030; wbs_dat_i = 32'hCAFE_0000;
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_acc_en_before", 32'(sram_en_o), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("rst_acc_en_after",  32'(sram_en_o),   32'h0);
      check_eq("rst_acc_core_rst",  32'(core_rst_no), 32'h0);
      check_eq("rst_acc_no_ack",    32'(wbs_ack_o),   32'h0);
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      mgmt_xfer(1'b0, 4'hF, CTRL_ADR, 32'h0, rd, lat, a_addr, a_we, a_wd);
      check_eq("rst_acc_ctrl", rd, 32'h0);
      mgmt_xfer(1'b0, 4'hF, 32'h3000_0030, 32'h0, rd, lat, a_addr, a_we, a_wd);
      check_eq("rst_acc_no_write", rd, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/subservient_mem_arbiter.md
Name: subservient_mem_arbiter

Overview:
- Shares one single-port 32-bit program/data SRAM between two masters: the management SoC Wishbone slave port and the subservient (SERV) core's memory bus.
- Holds the core in reset until the management SoC has loaded firmware and set a RUN bit.
- Sits between the top-level Wishbone slave pins and the SRAM macro, alongside the subservient core.

Parameters:
- AW, 10, SRAM word-address width (2^AW words of 32 bits).
- BASE_ADDR, 32'h3000_0000, management window base; only adr[31:24] is compared.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_ni  in  1  asynchronous reset, active low
- wbs_cyc_i  in  1  mgmt Wishbone cycle
- wbs_stb_i  in  1  mgmt strobe
- wbs_we_i  in  1  mgmt write enable
- wbs_sel_i  in  4  mgmt byte selects
- wbs_adr_i  in  32  mgmt byte address
- wbs_dat_i  in  32  mgmt write data
- wbs_ack_o  out  1  mgmt acknowledge
- wbs_dat_o  out  32  mgmt read data
- core_cyc_i  in  1  core request (servant-style, no stb)
- core_we_i  in  1  core write enable
- core_sel_i  in  4  core byte selects
- core_adr_i  in  32  core byte address
- core_dat_i  in  32  core write data
- core_ack_o  out  1  core acknowledge
- core_dat_o  out  32  core read data
- core_rst_no  out  1  core reset, active low
- sram_en_o  out  1  SRAM access enable
- sram_we_o  out  4  SRAM byte write enables
- sram_addr_o  out  AW  SRAM word address
- sram_wdata_o  out  32  SRAM write data
- sram_rdata_i  in  32  SRAM read data, valid the cycle after sram_en_o

Behaviour:
- Reset (async, wb_rst_ni=0): state IDLE; RUN=0; last_grant=CORE; all outputs 0, so core_rst_no=0.
- Decode: mgmt_req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24]==BASE_ADDR[31:24]).
  - wbs_adr_i[AW+2]=1 selects CTRL; otherwise SRAM word wbs_adr_i[AW+1:2].
  - Out-of-window mgmt requests are never acked.
- Core request: core_req = core_cyc_i & core_rst_no; word address core_adr_i[AW+1:2]; upper bits ignored, so addresses alias/wrap.
- FSM states: IDLE, REG, ACC, RESP.
  - IDLE:
    - mgmt_req to CTRL -> REG.
    - Otherwise, if any SRAM request: grant. When both request, grant the master not equal to last_grant; update last_grant.
    - On a grant: register the granted master's address/we/sel/wdata into the SRAM output flops -> ACC.
  - ACC: sram_en_o=1; sram_we_o = we ? sel : 4'b0 -> RESP.
  - RESP: sram_en_o=0; the granted master's ack_o=1 for exactly one cycle; dat_o = sram_rdata_i -> IDLE.
  - REG: wbs_ack_o=1 for one cycle; wbs_dat_o = {30'b0, core_rst_no, RUN}.
    - A write with wbs_sel_i[0]=1 loads RUN <= wbs_dat_i[0] at the end of the cycle.
    - -> IDLE.
- Latency: ack is asserted 3 cycles after the request is first seen in IDLE (IDLE, ACC, RESP); CTRL ack 2 cycles after. Throughput is one SRAM access per 3 cycles.
- core_rst_no is a flop equal to RUN delayed one cycle.
- Non-granted outputs: ack=0; dat_o holds 0 when not acking.
- Master drops cyc mid-access: the SRAM access still completes (writes take effect); ack is gated by the current request and suppressed.
- RUN cleared while a core access is in flight: the access completes; core_ack_o is suppressed because core_rst_no=0.
- Reset asserted mid-operation: immediate return to reset values; any in-flight SRAM write has sram_en_o forced to 0.

Test Plan:
- Reset, idle 10 cycles -> core_rst_no=0, no sram_en_o, all acks 0; core_cyc_i=1 during this time is never acked.
- Mgmt write 0xDEADBEEF to 0x3000_0010, sel=0xF -> sram_addr_o=4, sram_we_o=0xF, wdata=0xDEADBEEF in ACC; wbs_ack_o 3 cycles after request. A read-back returns 0xDEADBEEF.
- Mgmt write 1 to CTRL (wbs_adr_i=0x3000_0000 | 1<<(AW+2)) -> ack in 2 cycles; core_rst_no=1 one cycle later; CTRL read returns 0x3.
- Core and mgmt request in the same IDLE cycle after reset -> mgmt served first, then core. Repeat with both held -> grants alternate.
- Byte write sel=0x2, data 0x0000AB00 over 0x11223344 -> SRAM word reads 0x1122AB44.
- Assert wb_rst_ni low during ACC of a mgmt write -> sram_en_o=0 immediately, RUN=0, core_rst_no=0; no ack issued.
